// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit : iterative MULT/MULTU/DIV/DIVU engine with HI/LO registers
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic               b_zero_q, b_zero_d;
  logic [WIDTH-1:0]   raw_a_q, raw_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, dbz_q, dbz_d;

  // Operand conditioning: unsigned ops carry clear sign flags, so the
  // sign-correction step below needs no separate signed/unsigned test.
  logic               in_signed, in_sign_a, in_sign_b;
  logic [WIDTH-1:0]   in_mag_a, in_mag_b;
  assign in_signed = ~op[0];
  assign in_sign_a = in_signed & operand_a[WIDTH-1];
  assign in_sign_b = in_signed & operand_b[WIDTH-1];
  assign in_mag_a  = in_sign_a ? (~operand_a) + WIDTH'(1) : operand_a;
  assign in_mag_b  = in_sign_b ? (~operand_b) + WIDTH'(1) : operand_b;

  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next, product;
  logic [WIDTH-1:0]   quot, rem;
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? mag_b_q : '0};
  assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
  // Partial remainder is always below the divisor, so a non-negative trial
  // difference fits in WIDTH bits and bit WIDTH is a clean borrow flag.
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b_q};
  assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign product   = (sign_a_q ^ sign_b_q) ? (~acc_q) + (2*WIDTH)'(1) : acc_q;
  assign quot      = (sign_a_q ^ sign_b_q) ? (~acc_q[WIDTH-1:0]) + WIDTH'(1) : acc_q[WIDTH-1:0];
  assign rem       = sign_a_q ? (~acc_q[2*WIDTH-1:WIDTH]) + WIDTH'(1) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    b_zero_d = b_zero_q;
    raw_a_d  = raw_a_q;
    mag_b_d  = mag_b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wr_data;
        if (lo_we) lo_d = wr_data;
        if (start) begin
          op_d     = op;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          b_zero_d = (operand_b == '0);
          raw_a_d  = operand_a;
          mag_b_d  = in_mag_b;
          acc_d    = {{WIDTH{1'b0}}, in_mag_a};
          cnt_d    = CNT_W'(WIDTH - 1);
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d = op_q[1] ? div_next : mul_next;
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      FIX: begin
        if (!op_q[1]) begin
          hi_d = product[2*WIDTH-1:WIDTH];
          lo_d = product[WIDTH-1:0];
        end else if (b_zero_q) begin
          hi_d = raw_a_q;
          lo_d = {WIDTH{1'b1}};
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
        dbz_d   = op_q[1] & b_zero_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      raw_a_q  <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      b_zero_q <= b_zero_d;
      raw_a_q  <= raw_a_d;
      mag_b_q  <= mag_b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// tb_mult_div_unit : randomized and directed checks of mult_div_unit
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        hi_we, lo_we;
  logic [31:0] wr_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic edbz);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    edbz = 1'b0;
    case (o)
      2'd0: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFF_FFFF; edbz = 1'b1;
        end else if (o == 2'd2) begin
          sq = sa / sb; sr = sa % sb;
          p = 64'(sq); el = p[31:0];
          p = 64'(sr); eh = p[31:0];
        end else begin
          el = a / b; eh = a % b;
        end
      end
    endcase
  endtask

  // Issues one operation and returns at the negedge where done should be high.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int cyc);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = 2'd0; operand_a = '0; operand_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({hi, lo, busy, done, div_by_zero} !== {64'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dbz=%b, required all zero",
               hi, lo, busy, done, div_by_zero);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [1:0]  to [6] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3};
    logic [31:0] ta [6] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd100};
    logic [31:0] tb [6] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd7};
    logic [31:0] th [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd0, 32'd2};
    logic [31:0] tl [6] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd14};
    logic        tz [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int cyc;
    for (int i = 0; i < 6; i++) begin
      do_op(to[i], ta[i], tb[i], cyc);
      checks++;
      if (cyc !== 33 || done !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_timing: busy_cycles=%0d done=%b, required 33 and 1", i, cyc, done);
      end
      checks++;
      if (hi !== th[i] || lo !== tl[i] || div_by_zero !== tz[i]) begin
        errors++;
        $display("FAIL dir%0d_result: hi=%h lo=%h dbz=%b, required hi=%h lo=%h dbz=%b",
                 i, hi, lo, div_by_zero, th[i], tl[i], tz[i]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_pulse: done=%b dbz=%b one cycle later, required 0 0", i, done, div_by_zero);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b, eh, el;
    logic        ez;
    int cyc;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(0, 15));
        2: a = 32'h80000000;
        3: b = 32'hFFFFFFFF;
        default: ;
      endcase
      model(o, a, b, eh, el, ez);
      do_op(o, a, b, cyc);
      checks++;
      if (cyc !== 33 || done !== 1'b1 || hi !== eh || lo !== el || div_by_zero !== ez) begin
        errors++;
        $display("FAIL rand%0d op=%0d a=%h b=%h: cyc=%0d done=%b hi=%h lo=%h dbz=%b, required 33 1 hi=%h lo=%h dbz=%b",
                 i, o, a, b, cyc, done, hi, lo, div_by_zero, eh, el, ez);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    @(negedge clk);
    start = 1'b1; op = 2'd3; operand_a = 32'd100; operand_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      start = (cyc == 10);
      if (cyc == 10) begin op = 2'd1; operand_a = 32'd2; operand_b = 32'd3; end
      hi_we = (cyc == 12);
      wr_data = 32'hDEAD;
      @(negedge clk);
    end
    start = 1'b0; hi_we = 1'b0;
    checks++;
    if (cyc !== 33 || done !== 1'b1 || hi !== 32'd2 || lo !== 32'd14) begin
      errors++;
      $display("FAIL busy_ignore: cyc=%0d done=%b hi=%h lo=%h, required 33 1 hi=2 lo=14", cyc, done, hi, lo);
    end
    // back-to-back: start in the done cycle
    start = 1'b1; op = 2'd1; operand_a = 32'd5; operand_b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_accept: busy=%b, required 1", busy);
    end
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc !== 33 || hi !== 32'd0 || lo !== 32'd30) begin
      errors++;
      $display("FAIL back_to_back_result: cyc=%0d hi=%h lo=%h, required 33 hi=0 lo=30", cyc, hi, lo);
    end
  endtask

  task automatic test_mt_write();
    int cyc;
    @(negedge clk);
    hi_we = 1'b1; wr_data = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b1; wr_data = 32'h5678;
    checks++;
    if (hi !== 32'h1234) begin
      errors++;
      $display("FAIL mthi: hi=%h, required 00001234", hi);
    end
    @(negedge clk);
    lo_we = 1'b0;
    checks++;
    if (hi !== 32'h1234 || lo !== 32'h5678) begin
      errors++;
      $display("FAIL mtlo: hi=%h lo=%h, required 00001234 00005678", hi, lo);
    end
    hi_we = 1'b1; wr_data = 32'hCAFE;
    start = 1'b1; op = 2'd1; operand_a = 32'd3; operand_b = 32'd4;
    @(negedge clk);
    hi_we = 1'b0; start = 1'b0;
    checks++;
    if (hi !== 32'hCAFE || busy !== 1'b1) begin
      errors++;
      $display("FAIL mt_with_start: hi=%h busy=%b, required 0000cafe 1", hi, busy);
    end
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd12) begin
      errors++;
      $display("FAIL mt_overwritten: hi=%h lo=%h, required 0 12", hi, lo);
    end
  endtask

  task automatic test_async_reset();
    int dones;
    @(negedge clk);
    start = 1'b1; op = 2'd0; operand_a = 32'hFFFF_F001; operand_b = 32'h0000_1234;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: hi=%h lo=%h busy=%b done=%b, required 0 0 0 0", hi, lo, busy, done);
    end
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    checks++;
    if (dones !== 0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_abort: activity_cycles=%0d hi=%h lo=%h, required 0 0 0", dones, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_mt_write();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
